cim_weight_loader: RTL

Sequential weight-load front end that sits directly upstream of cim_array_ctrl and drives its D, WA and cima inputs. It accepts a byte stream over a valid/ready handshake and packs each three bytes into a 24-bit weight word. It issues one registered write strobe per word at auto-incrementing addresses within the selected bank. A command interface sets the bank, base address and word count for each load burst.

---
 rtl/cim_weight_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cim_weight_loader.sv
// Weight-load front end for cim_array_ctrl: packs a byte stream into weight
// words and issues one registered write strobe per word at incrementing addresses.
module cim_weight_loader #(
    parameter int DATA_W = 24,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_bank,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              abort,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] D,
    output logic [ADDR_W-1:0] WA,
    output logic              cima,
    output logic              wen,
    output logic              busy,
    output logic              done
);

    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] BYTE_ONE = 1;
    localparam logic [ADDR_W:0] WORD_ONE = 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state;
    logic              burst_bank;
    logic [ADDR_W-1:0] burst_base;
    logic [ADDR_W:0]   burst_len;
    logic [CNT_W-1:0]  byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [DATA_W-1:0] pack;
    logic [DATA_W-1:0] pack_next;

    assign s_ready      = (state == S_COLLECT);
    assign wen          = (state == S_WRITE);
    assign done         = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign word_cnt_inc = word_cnt + WORD_ONE;

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        pack_next = pack;
        pack_next[byte_cnt*BYTE_W +: BYTE_W] = s_data;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            burst_bank <= 1'b0;
            burst_base <= '0;
            burst_len  <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            pack       <= '0;
            D          <= '0;
            WA         <= '0;
            cima       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        burst_bank <= cfg_bank;
                        burst_base <= cfg_base;
                        burst_len  <= cfg_len;
                        byte_cnt   <= '0;
                        word_cnt   <= '0;
                        pack       <= '0;
                        state      <= (cfg_len == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        // A partially packed word is thrown away.
                        state    <= S_IDLE;
                        byte_cnt <= '0;
                        pack     <= '0;
                    end else if (s_valid) begin
                        pack <= pack_next;
                        if (byte_cnt == LAST_BYTE) begin
                            D     <= pack_next;
                            WA    <= burst_base + word_cnt[ADDR_W-1:0];
                            cima  <= burst_bank;
                            state <= S_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    // The strobe this cycle already counts, even when aborted.
                    word_cnt <= word_cnt_inc;
                    byte_cnt <= '0;
                    if (abort)
                        state <= S_IDLE;
                    else if (word_cnt_inc == burst_len)
                        state <= S_DONE;
                    else
                        state <= S_COLLECT;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
